object_centroid: RTL and testbench

OBJECT_CENTROID -- requirements
Module: object_centroid

---
 rtl/object_centroid_if.sv | 26 ++
 rtl/object_centroid.sv | 95 +++++++++
 tb/tb_object_centroid.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/object_centroid_if.sv
// object_centroid_if: pixel stream in, centroid result out
// slave: seen by object_centroid (pixel inputs, result outputs); master: seen by the pixel source/consumer
interface object_centroid_if #(
    parameter int COLOR_WIDTH = 10,
    parameter int DISP_WIDTH  = 11
);
    logic                   enable;
    logic                   pix_valid;
    logic                   frame_end;
    logic [COLOR_WIDTH-1:0] curr;
    logic [DISP_WIDTH-1:0]  x_pos;
    logic [DISP_WIDTH-1:0]  y_pos;
    logic [DISP_WIDTH-1:0]  x_obj;
    logic [DISP_WIDTH-1:0]  y_obj;
    logic                   obj_found;
    logic                   obj_valid;
    logic                   overrun;
    modport slave (
        input  enable, pix_valid, frame_end, curr, x_pos, y_pos,
        output x_obj, y_obj, obj_found, obj_valid, overrun
    );
    modport master (
        output enable, pix_valid, frame_end, curr, x_pos, y_pos,
        input  x_obj, y_obj, obj_found, obj_valid, overrun
    );
endinterface

// File: rtl/object_centroid.sv
// object_centroid: thresholded-pixel centroid per frame with a serial restoring divider
// clk: clock; reset: sync active-high; pix (slave): enable/pix_valid/curr/x_pos/y_pos/frame_end in, x_obj/y_obj/obj_found/obj_valid/overrun out
module object_centroid #(
    parameter int COLOR_WIDTH   = 10,
    parameter int DISP_WIDTH    = 11,
    parameter int PIX_THRESHOLD = 512,
    parameter int MIN_PIXELS    = 4
) (
    input logic              clk,
    input logic              reset,
    object_centroid_if.slave pix
);
    localparam int CNT_W  = 2*DISP_WIDTH+1;
    localparam int SUM_W  = 3*DISP_WIDTH+1;
    localparam int STEP_W = $clog2(SUM_W);
    localparam logic [COLOR_WIDTH:0] THR     = (COLOR_WIDTH+1)'(PIX_THRESHOLD);
    localparam logic [CNT_W-1:0]     MIN_CNT = CNT_W'(MIN_PIXELS);
    localparam logic [STEP_W-1:0]    LAST    = STEP_W'(SUM_W-1);
    typedef enum logic [1:0] {IDLE, DIVIDE, PUBLISH} state_t;
    state_t state, state_n;
    logic hit, fin, found;
    logic [1:0][DISP_WIDTH-1:0] pos;
    logic [1:0][SUM_W-1:0] sum, sum_n, dq, dq_n;
    logic [1:0][CNT_W-1:0] rem, rem_n;
    logic [CNT_W-1:0] cnt, cnt_n, dvs;
    logic [STEP_W-1:0] step;

    // lane 0 is x, lane 1 is y
    assign pos   = {pix.y_pos, pix.x_pos};
    assign hit   = pix.pix_valid & pix.enable & ({1'b0, pix.curr} >= THR);
    assign cnt_n = cnt + CNT_W'(hit);
    assign found = (dvs != '0) && (dvs >= MIN_CNT);

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic [CNT_W:0] t, s;
        assign sum_n[i] = sum[i] + (hit ? SUM_W'(pos[i]) : '0);
        // dq shifts the dividend out at the top and the quotient in at the bottom;
        // rem < dvs always, so the sign bit of t - dvs is exactly the borrow
        assign t        = {rem[i], dq[i][SUM_W-1]};
        assign s        = t - {1'b0, dvs};
        assign rem_n[i] = s[CNT_W] ? t[CNT_W-1:0] : s[CNT_W-1:0];
        assign dq_n[i]  = {dq[i][SUM_W-2:0], ~s[CNT_W]};
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_comb begin
        fin     = (state == DIVIDE) && (step == LAST);
        state_n = state == IDLE   ? (pix.frame_end ? DIVIDE : IDLE) :
                  state == DIVIDE ? (fin ? PUBLISH : DIVIDE) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum           <= '0;
            cnt           <= '0;
            dq            <= '0;
            rem           <= '0;
            dvs           <= '0;
            step          <= '0;
            pix.x_obj     <= '0;
            pix.y_obj     <= '0;
            pix.obj_found <= 1'b0;
            pix.obj_valid <= 1'b0;
            pix.overrun   <= 1'b0;
        end else begin
            sum           <= pix.frame_end ? '0 : sum_n;
            cnt           <= pix.frame_end ? '0 : cnt_n;
            pix.obj_valid <= fin;
            pix.overrun   <= pix.frame_end && (state != IDLE);
            if (state == IDLE && pix.frame_end) begin
                dq   <= sum_n;
                rem  <= '0;
                dvs  <= cnt_n;
                step <= '0;
            end else if (state == DIVIDE) begin
                step <= step + STEP_W'(1);
                // an empty frame leaves the divider idle; its result is never used
                if (dvs != '0) begin
                    dq  <= dq_n;
                    rem <= rem_n;
                end
            end
            // outputs load on the final divide step so they are current during PUBLISH
            if (fin) begin
                pix.obj_found <= found;
                if (found) begin
                    pix.x_obj <= dq_n[0][DISP_WIDTH-1:0];
                    pix.y_obj <= dq_n[1][DISP_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_object_centroid.sv
// tb_object_centroid: scoreboard bench for object_centroid at MIN_PIXELS 4 and 1
module tb_object_centroid;
    typedef struct {
        int cyc;
        int x;
        int y;
        int f;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    exp_t q0[$], q1[$];
    int oq0[$], oq1[$];

    object_centroid_if #(.COLOR_WIDTH(10), .DISP_WIDTH(11)) i0 ();
    object_centroid_if #(.COLOR_WIDTH(10), .DISP_WIDTH(11)) i1 ();

    object_centroid u0 (.clk(clk), .reset(reset), .pix(i0.slave));
    object_centroid #(.MIN_PIXELS(1)) u1 (.clk(clk), .reset(reset), .pix(i1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic ov, input int x, input int y, input int f);
        exp_t e;
        int c;
        if (v) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_valid%0d: obj_valid=1 at cycle %0d, expected 0", k, cyc);
            end else begin
                if (k == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk($sformatf("latency%0d", k), cyc, e.cyc);
                chk($sformatf("x_obj%0d", k), x, e.x);
                chk($sformatf("y_obj%0d", k), y, e.y);
                chk($sformatf("obj_found%0d", k), f, e.f);
            end
        end
        if (ov) begin
            if ((k == 0 ? oq0.size() : oq1.size()) == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_overrun%0d: overrun=1 at cycle %0d, expected 0", k, cyc);
            end else begin
                if (k == 0) c = oq0.pop_front();
                else c = oq1.pop_front();
                chk($sformatf("overrun_cycle%0d", k), cyc, c);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, i0.obj_valid, i0.overrun, int'(i0.x_obj), int'(i0.y_obj), int'(i0.obj_found));
        mon(1, i1.obj_valid, i1.overrun, int'(i1.x_obj), int'(i1.y_obj), int'(i1.obj_found));
    end

    task automatic drv(input logic v, input logic en, input logic fe, input int c, input int x, input int y);
        i0.pix_valid = v;  i0.enable = en;  i0.frame_end = fe;
        i0.curr = 10'(c);  i0.x_pos = 11'(x); i0.y_pos = 11'(y);
        i1.pix_valid = v;  i1.enable = en;  i1.frame_end = fe;
        i1.curr = 10'(c);  i1.x_pos = 11'(x); i1.y_pos = 11'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input int c = 1023);
        drv(1'b1, 1'b1, 1'b0, c, x, y);
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic fend(input int x0, input int y0, input int f0, input int x1, input int y1, input int f1);
        q0.push_back(exp_t'{cyc + 35, x0, y0, f0});
        q1.push_back(exp_t'{cyc + 35, x1, y1, f1});
        drv(1'b0, 1'b1, 1'b1, 0, 0, 0);
    endtask

    task automatic zchk(input string tag);
        chk({tag, "_x0"}, int'(i0.x_obj), 0);
        chk({tag, "_y0"}, int'(i0.y_obj), 0);
        chk({tag, "_f0"}, int'(i0.obj_found), 0);
        chk({tag, "_v0"}, int'(i0.obj_valid), 0);
        chk({tag, "_o0"}, int'(i0.overrun), 0);
        chk({tag, "_x1"}, int'(i1.x_obj), 0);
        chk({tag, "_f1"}, int'(i1.obj_found), 0);
        chk({tag, "_v1"}, int'(i1.obj_valid), 0);
    endtask

    initial begin
        idle(3);
        zchk("reset");
        reset = 1'b0;
        idle(2);
        // single pixel: only the MIN_PIXELS=1 instance finds it
        pix(100, 50);
        fend(0, 0, 0, 100, 50, 1);
        idle(40);
        // 10x10 block plus sub-threshold and invalid distractors
        pix(2000, 2000, 511);
        drv(1'b0, 1'b1, 1'b0, 1023, 2000, 2000);
        for (int y = 30; y < 40; y++)
            for (int x = 20; x < 30; x++)
                pix(x, y, 600);
        fend(24, 34, 1, 24, 34, 1);
        idle(40);
        // three pixels at exactly the threshold
        pix(0, 0, 512);
        pix(2000, 2000, 511);
        pix(3, 3, 512);
        drv(1'b0, 1'b1, 1'b0, 1023, 1500, 1500);
        pix(6, 6, 512);
        fend(24, 34, 0, 3, 3, 1);
        idle(40);
        // enable low: nothing accumulates
        repeat (5) drv(1'b1, 1'b0, 1'b0, 1023, 700, 700);
        fend(24, 34, 0, 3, 3, 0);
        idle(40);
        // overrun: second frame_end 10 cycles after the first
        for (int i = 0; i < 4; i++) pix(10 + i, 10);
        fend(11, 10, 1, 11, 10, 1);
        repeat (9) pix(2000, 2000);
        oq0.push_back(cyc + 1);
        oq1.push_back(cyc + 1);
        drv(1'b0, 1'b1, 1'b1, 0, 0, 0);
        repeat (4) pix(400, 300);
        idle(30);
        fend(400, 300, 1, 400, 300, 1);
        idle(40);
        // largest coordinate
        repeat (4) pix(2047, 2047);
        fend(2047, 2047, 1, 2047, 2047, 1);
        idle(40);
        // reset 12 cycles into DIVIDE, coinciding with frame_end and a qualifying pixel
        repeat (4) pix(500, 500);
        drv(1'b0, 1'b1, 1'b1, 0, 0, 0);
        idle(11);
        reset = 1'b1;
        drv(1'b1, 1'b1, 1'b1, 1023, 5, 5);
        reset = 1'b0;
        zchk("midreset");
        idle(45);
        for (int i = 0; i < 4; i++) pix(7 + i, 9);
        fend(8, 9, 1, 8, 9, 1);
        idle(40);
        chk("pending_valid0", q0.size(), 0);
        chk("pending_valid1", q1.size(), 0);
        chk("pending_overrun0", oq0.size(), 0);
        chk("pending_overrun1", oq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
